fifo_uart_tx: RTL and testbench

//  Downstream drain stage for the 16x8 synchronous FIFO: pops bytes whenever the FIFO is non-empty
//  and serialises each byte as an asynchronous serial frame (start, 8 data LSB-first, stop).

---
 rtl/fifo_uart_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 35 +++
 rtl/fifo_uart_tx.sv | 142 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared constants for the FIFO-drain UART transmitter: data width, default baud divisor
// and the legacy-compatible state encodings.
package fifo_uart_pkg;

   localparam int unsigned DATA_W               = 8;
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t FETCH  = 3'd1;
   localparam state_t LOAD   = 3'd2;
   localparam state_t START  = 3'd3;
   localparam state_t DATA   = 3'd4;
   localparam state_t PARITY = 3'd5;
   localparam state_t STOP   = 3'd6;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, ticks on the last count of each bit,
// and restarts from zero whenever clear is asserted.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte when idle and serialises it as start/8N/stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              tx_enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_read_data,
   output logic              fifo_r_enable,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [2:0] LAST_DATA = 3'(DATA_W - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic              tx_q, tx_d;
   logic              baud_clear;
   logic              bit_tick;
`ifdef UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clock),
      .rst  (reset),
      .clear(baud_clear),
      .tick (bit_tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (tx_enable && !fifo_empty) begin
               state_d = FETCH;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            shift_d = fifo_read_data;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_read_data;
`endif
            state_d = START;
         end
         START: begin
            if (bit_tick) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               shift_d   = {1'b0, shift_q[DATA_W-1:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_tick) begin
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_tick) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == LAST_STOP) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) begin
         bit_cnt_d = '0;
      end
   end

   // Line level is derived from the next state so tx_q flips on the same edge as state_q.
   always_comb begin
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = parity_q;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   assign baud_clear = (state_d != state_q) || (state_q == IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign tx            = tx_q;
   assign busy          = (state_q != IDLE);
   assign fifo_r_enable = (state_q == FETCH);
   assign frame_done    = (state_q == STOP) && bit_tick && (bit_cnt_q == LAST_STOP);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds the DUT, a line decoder
// reconstructs each frame and checks it against the queue of expected bytes.
module tb_fifo_uart_tx;

   localparam int CPB  = 4;
   localparam int STOP = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PAR  = 1;
`else
   localparam int PAR  = 0;
`endif
   localparam int NB = 10 + STOP - 1 + PAR;

   typedef struct {
      logic [7:0] data;
      logic       par;
   } sb_entry_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       tx_enable;
   logic       fifo_empty;
   logic [7:0] fifo_read_data = 8'h00;
   logic       fifo_r_enable;
   logic       tx;
   logic       busy;
   logic       frame_done;

   logic [7:0] mem [0:63];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic       pop_req = 1'b0;

   sb_entry_t  exp_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         pop_cnt = 0;
   int         fd_total = 0;
   int         frames_seen = 0;
   int         gap_from = 1000;
   int         gap_to = 0;
   logic       in_frame = 1'b0;

   fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .STOP_BITS   (STOP)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .tx_enable     (tx_enable),
      .fifo_empty    (fifo_empty),
      .fifo_read_data(fifo_read_data),
      .fifo_r_enable (fifo_r_enable),
      .tx            (tx),
      .busy          (busy),
      .frame_done    (frame_done)
   );

   always #5 clock = ~clock;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endfunction

   // FIFO model: registered read data, one-cycle latency after the pop strobe.
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (pop_req) begin
         fifo_read_data <= mem[rd_ptr[5:0]];
         rd_ptr         <= rd_ptr + 1;
      end
   end

   always @(negedge clock) begin
      pop_req <= fifo_r_enable;
      if (fifo_r_enable) begin
         pop_cnt <= pop_cnt + 1;
         check("pop_while_empty", {31'b0, fifo_empty}, 32'd0);
      end
      if (frame_done) fd_total <= fd_total + 1;
   end

   task automatic push(input logic [7:0] d, input bit expect_frame);
      sb_entry_t e;
      mem[wr_ptr[5:0]] = d;
      wr_ptr = wr_ptr + 1;
      if (expect_frame) begin
         e.data = d;
         e.par  = ^d;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain(input string name, input int limit);
      bit done = 0;
      for (int i = 0; i < limit && !done; i++) begin
         @(negedge clock);
         if (exp_q.size() == 0 && !in_frame && busy === 1'b0 && fifo_empty) done = 1;
      end
      check(name, {31'b0, done}, 32'd1);
   endtask

   task automatic wait_pop(input string name, input int limit);
      bit seen = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clock);
         if (fifo_r_enable === 1'b1) seen = 1;
      end
      check(name, {31'b0, seen}, 32'd1);
   endtask

   // Line decoder and scoreboard monitor.
   initial begin : line_decoder
      logic [7:0] data;
      logic       v, start_bit, par_bit, stop_ok, glitch, fd_bad, busy_bad, abort;
      int         fd_cnt, start_cyc, last_end;
      sb_entry_t  e;
      last_end = -1;
      forever begin
         @(negedge clock);
         if (reset !== 1'b0 || tx !== 1'b0) continue;
         in_frame = 1'b1;
         start_cyc = cyc;
         abort = 0; glitch = 0; fd_bad = 0; busy_bad = 0; stop_ok = 1;
         start_bit = 1'b1; par_bit = 1'b0; data = '0; fd_cnt = 0; v = 1'b0;
         if (frames_seen >= gap_from && frames_seen < gap_to && last_end >= 0)
            check("idle_gap", start_cyc - last_end - 1, 32'd3);
         for (int b = 0; b < NB && !abort; b++) begin
            for (int c = 0; c < CPB && !abort; c++) begin
               if (b != 0 || c != 0) @(negedge clock);
               if (reset !== 1'b0) begin
                  abort = 1;
               end else begin
                  if (c == 0) v = tx;
                  else if (tx !== v) glitch = 1;
                  if (c == CPB / 2) begin
                     if (b == 0) start_bit = tx;
                     else if (b <= 8) data[b-1] = tx;
                     else if (PAR == 1 && b == 9) par_bit = tx;
                     else if (tx !== 1'b1) stop_ok = 0;
                  end
                  if (frame_done === 1'b1) begin
                     fd_cnt++;
                     if (!(b == NB - 1 && c == CPB - 1)) fd_bad = 1;
                  end
                  if (busy !== 1'b1) busy_bad = 1;
               end
            end
         end
         if (abort) begin
            in_frame = 1'b0;
            last_end = -1;
            continue;
         end
         @(negedge clock);
         check("idle_after_frame_len", {31'b0, busy}, 32'd0);
         last_end = cyc - 1;
         check("start_bit", {31'b0, start_bit}, 32'd0);
         check("stop_bit", {31'b0, stop_ok}, 32'd1);
         check("tx_stable_in_bit", {31'b0, glitch}, 32'd0);
         check("frame_done_count", fd_cnt, 32'd1);
         check("frame_done_position", {31'b0, fd_bad}, 32'd0);
         check("busy_in_frame", {31'b0, busy_bad}, 32'd0);
         check("sb_has_entry", exp_q.size(), (exp_q.size() == 0) ? 32'd1 : exp_q.size());
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("data_byte", {24'b0, data}, {24'b0, e.data});
            if (PAR == 1) check("parity_bit", {31'b0, par_bit}, {31'b0, e.par});
         end
         frames_seen++;
         in_frame = 1'b0;
      end
   end

   initial begin : stimulus
      int p0, f0, bad;
      reset = 1'b1;
      tx_enable = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      check("rst_tx", {31'b0, tx}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_pop", {31'b0, fifo_r_enable}, 32'd0);
      check("rst_frame_done", {31'b0, frame_done}, 32'd0);
      reset = 1'b0;

      // Empty FIFO with transmit enabled: line stays idle, nothing popped.
      tx_enable = 1'b1;
      p0 = pop_cnt;
      bad = 0;
      repeat (100) begin
         @(negedge clock);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("empty_line_idle", bad, 32'd0);
      check("empty_no_pop", pop_cnt - p0, 32'd0);

      // Single byte 0xA5.
      p0 = pop_cnt;
      f0 = fd_total;
      push(8'hA5, 1);
      wait_drain("a5_drain", 200);
      check("a5_pops", pop_cnt - p0, 32'd1);
      check("a5_frame_done", fd_total - f0, 32'd1);

      // Three back-to-back bytes; gaps checked on the second and third frames.
      p0 = pop_cnt;
      gap_from = frames_seen + 1;
      gap_to = frames_seen + 3;
      push(8'h01, 1);
      push(8'h02, 1);
      push(8'h03, 1);
      wait_drain("b2b_drain", 400);
      check("b2b_pops", pop_cnt - p0, 32'd3);
      gap_to = 0;

      // Drop tx_enable in the middle of 0x3C's data bits with 0x7E still queued.
      p0 = pop_cnt;
      push(8'h3C, 1);
      push(8'h7E, 1);
      wait_pop("en_first_pop", 50);
      repeat (12) @(negedge clock);
      #1 tx_enable = 1'b0;
      repeat (80) @(negedge clock);
      check("en_held_pops", pop_cnt - p0, 32'd1);
      check("en_held_queued", {31'b0, fifo_empty}, 32'd0);
      check("en_held_idle", {31'b0, busy}, 32'd0);
      check("en_held_sb", exp_q.size(), 32'd1);
      tx_enable = 1'b1;
      wait_drain("en_resume_drain", 200);
      check("en_resume_pops", pop_cnt - p0, 32'd2);

      // Reset during data bit 4 of 0xFF; that byte is lost, 0x5A follows cleanly.
      p0 = pop_cnt;
      push(8'hFF, 0);
      push(8'h5A, 1);
      wait_pop("rst_mid_pop", 50);
      repeat (23) @(negedge clock);
      check("rst_mid_busy_before", {31'b0, busy}, 32'd1);
      #1 reset = 1'b1;
      #1;
      check("rst_mid_tx", {31'b0, tx}, 32'd1);
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      check("rst_mid_pop", {31'b0, fifo_r_enable}, 32'd0);
      repeat (3) @(negedge clock);
      #1 reset = 1'b0;
      wait_drain("rst_after_drain", 200);
      check("rst_after_pops", pop_cnt - p0, 32'd2);

`ifdef UART_TX_PARITY_EN
      // 0x07 has odd weight (parity 1), 0x03 even weight (parity 0); frames are 44 cycles.
      p0 = pop_cnt;
      push(8'h07, 1);
      push(8'h03, 1);
      wait_drain("par_drain", 300);
      check("par_pops", pop_cnt - p0, 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #100000;
      n_err++;
      $display("FAIL watchdog: got timeout, want completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
